// File: rtl/trigger_gen_pkg.sv
// rtl/trigger_gen_pkg.sv - shared state type and constants for periodic_trigger_generator
package trigger_gen_pkg;

    localparam int DEFAULT_PERIOD_WIDTH      = 32;
    localparam int DEFAULT_PULSE_WIDTH_WIDTH = 16;
    localparam int DEFAULT_BURST_WIDTH       = 16;
    localparam int MIN_PERIOD                = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } trig_state_t;

endpackage

// File: rtl/trigger_phase_counter.sv
// rtl/trigger_phase_counter.sv - phase counter with per-period latching of period/pulse width and wrap detect
module trigger_phase_counter
    import trigger_gen_pkg::*;
#(
    parameter int PERIOD_WIDTH      = DEFAULT_PERIOD_WIDTH,
    parameter int PULSE_WIDTH_WIDTH = DEFAULT_PULSE_WIDTH_WIDTH
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         load,
    input  logic                         advance,
    input  logic                         clear,
    input  logic [PERIOD_WIDTH-1:0]      period,
    input  logic [PULSE_WIDTH_WIDTH-1:0] pulse_width,
    output logic [PERIOD_WIDTH-1:0]      phase,
    output logic [PERIOD_WIDTH-1:0]      phase_next,
    output logic                         in_pulse_next,
    output logic                         wrap
);

    localparam int CW = (PERIOD_WIDTH > PULSE_WIDTH_WIDTH) ? PERIOD_WIDTH : PULSE_WIDTH_WIDTH;

    logic [PERIOD_WIDTH-1:0]      period_eff;
    logic [PERIOD_WIDTH-1:0]      period_m1;
    logic [PERIOD_WIDTH-1:0]      period_in_eff;
    logic [PERIOD_WIDTH-1:0]      period_in_m1;
    logic [PULSE_WIDTH_WIDTH-1:0] pw_eff;
    logic [PULSE_WIDTH_WIDTH-1:0] pw_in_eff;
    logic [PULSE_WIDTH_WIDTH-1:0] pw_next;
    logic                         latch;

    // Clamp the period and keep at least one low cycle per period.
    always_comb begin
        period_in_eff = (period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : period;
        period_in_m1  = period_in_eff - 1'b1;
        if (CW'(pulse_width) > CW'(period_in_m1)) begin
            pw_in_eff = PULSE_WIDTH_WIDTH'(period_in_m1);
        end else begin
            pw_in_eff = pulse_width;
        end
    end

    assign period_m1 = period_eff - 1'b1;
    assign wrap      = (phase == period_m1);
    assign latch     = !clear && (load || (advance && wrap));

    always_comb begin
        phase_next = phase;
        if (clear || load) begin
            phase_next = '0;
        end else if (advance) begin
            phase_next = wrap ? '0 : phase + 1'b1;
        end
        pw_next       = latch ? pw_in_eff : pw_eff;
        in_pulse_next = (CW'(phase_next) < CW'(pw_next));
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            phase      <= '0;
            period_eff <= PERIOD_WIDTH'(MIN_PERIOD);
            pw_eff     <= '0;
        end else begin
            phase  <= phase_next;
            pw_eff <= pw_next;
            if (latch) begin
                period_eff <= period_in_eff;
            end
        end
    end

endmodule

// File: rtl/periodic_trigger_generator.sv
// rtl/periodic_trigger_generator.sv - periodic pulse/strobe generator FSM; burst mode under TRIGGER_GEN_BURST_EN
module periodic_trigger_generator
    import trigger_gen_pkg::*;
#(
    parameter int PERIOD_WIDTH      = DEFAULT_PERIOD_WIDTH,
    parameter int PULSE_WIDTH_WIDTH = DEFAULT_PULSE_WIDTH_WIDTH,
    parameter int BURST_WIDTH       = DEFAULT_BURST_WIDTH
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         enable,
    input  logic                         start,
    input  logic                         stop,
    input  logic [PERIOD_WIDTH-1:0]      period,
    input  logic [PULSE_WIDTH_WIDTH-1:0] pulse_width,
    input  logic [BURST_WIDTH-1:0]       burst_count,
    output logic                         pulse_out,
    output logic                         period_strobe,
    output logic                         running,
    output logic                         burst_done,
    output logic [PERIOD_WIDTH-1:0]      phase,
    output logic [BURST_WIDTH-1:0]       periods_emitted
);

    trig_state_t             state;
    trig_state_t             state_next;
    logic                    load;
    logic                    advance;
    logic                    clear;
    logic                    wrap;
    logic                    in_pulse_next;
    logic                    burst_hit;
    logic                    running_next;
    logic [PERIOD_WIDTH-1:0] phase_next;

    trigger_phase_counter #(
        .PERIOD_WIDTH      (PERIOD_WIDTH),
        .PULSE_WIDTH_WIDTH (PULSE_WIDTH_WIDTH)
    ) u_phase_counter (
        .clk           (clk),
        .aresetn       (aresetn),
        .load          (load),
        .advance       (advance),
        .clear         (clear),
        .period        (period),
        .pulse_width   (pulse_width),
        .phase         (phase),
        .phase_next    (phase_next),
        .in_pulse_next (in_pulse_next),
        .wrap          (wrap)
    );

    // Disable beats stop beats start; stop in IDLE is a harmless clear.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        clear      = 1'b0;
        if (!enable || stop) begin
            state_next = ST_IDLE;
            clear      = 1'b1;
        end else if (start) begin
            state_next = ST_RUNNING;
            load       = 1'b1;
        end else if (state == ST_RUNNING) begin
            if (wrap && burst_hit) begin
                state_next = ST_DONE;
                clear      = 1'b1;
            end else begin
                advance = 1'b1;
            end
        end
    end

    assign running_next = (state_next == ST_RUNNING);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            running         <= 1'b0;
            pulse_out       <= 1'b0;
            period_strobe   <= 1'b0;
            periods_emitted <= '0;
        end else begin
            state         <= state_next;
            running       <= running_next;
            pulse_out     <= running_next && in_pulse_next;
            period_strobe <= running_next && (phase_next == '0);
            if (load) begin
                periods_emitted <= BURST_WIDTH'(1);
            end else if (advance && wrap && !(&periods_emitted)) begin
                periods_emitted <= periods_emitted + 1'b1;
            end
        end
    end

`ifdef TRIGGER_GEN_BURST_EN
    logic [BURST_WIDTH-1:0] burst_target;

    // A zero target means continuous operation.
    assign burst_hit = (burst_target != '0) && (periods_emitted == burst_target);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            burst_target <= '0;
            burst_done   <= 1'b0;
        end else begin
            burst_done <= (state_next == ST_DONE);
            if (load) begin
                burst_target <= burst_count;
            end
        end
    end
`else
    logic unused_burst_count;

    assign unused_burst_count = ^burst_count;
    assign burst_hit          = 1'b0;
    assign burst_done         = 1'b0;
`endif

endmodule

// File: tb/tb_periodic_trigger_generator.sv
// tb/tb_periodic_trigger_generator.sv - scoreboard bench with a period-level reference model
module tb_periodic_trigger_generator;

    localparam int PW_W  = 8;
    localparam int PU_W  = 6;
    localparam int B_W   = 4;
    localparam int E_MAX = (1 << B_W) - 1;
`ifdef TRIGGER_GEN_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            aresetn;
    logic            enable;
    logic            start;
    logic            stop;
    logic [PW_W-1:0] period;
    logic [PU_W-1:0] pulse_width;
    logic [B_W-1:0]  burst_count;
    logic            pulse_out;
    logic            period_strobe;
    logic            running;
    logic            burst_done;
    logic [PW_W-1:0] phase;
    logic [B_W-1:0]  periods_emitted;

    periodic_trigger_generator #(
        .PERIOD_WIDTH      (PW_W),
        .PULSE_WIDTH_WIDTH (PU_W),
        .BURST_WIDTH       (B_W)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .enable          (enable),
        .start           (start),
        .stop            (stop),
        .period          (period),
        .pulse_width     (pulse_width),
        .burst_count     (burst_count),
        .pulse_out       (pulse_out),
        .period_strobe   (period_strobe),
        .running         (running),
        .burst_done      (burst_done),
        .phase           (phase),
        .periods_emitted (periods_emitted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pulse;
        int strobe;
        int run;
        int done;
        int ph;
        int emit;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur_per  = 10;
    int   cur_pw   = 3;
    int   cur_bc   = 0;

    // Model: mode 0=idle 1=running 2=done; position within the current period.
    int m_mode  = 0;
    int m_pos   = 0;
    int m_len   = 2;
    int m_high  = 0;
    int m_emit  = 0;
    int m_burst = 0;

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic begin_period();
        m_len  = (cur_per < 2) ? 2 : cur_per;
        m_high = (cur_pw > m_len - 1) ? m_len - 1 : cur_pw;
        m_pos  = 0;
    endtask

    task automatic model_step(input bit en, input bit st, input bit sp);
        if (!en || sp) begin
            m_mode = 0;
            m_pos  = 0;
        end else if (st) begin
            m_mode  = 1;
            m_emit  = 1;
            m_burst = cur_bc;
            begin_period();
        end else if (m_mode == 1) begin
            if (m_pos + 1 < m_len) begin
                m_pos++;
            end else if (BURST_EN && m_burst != 0 && m_emit == m_burst) begin
                m_mode = 2;
                m_pos  = 0;
            end else begin
                begin_period();
                if (m_emit < E_MAX) m_emit++;
            end
        end
    endtask

    task automatic step(input bit en, input bit st, input bit sp);
        exp_t e;
        @(negedge clk);
        enable      = en;
        start       = st;
        stop        = sp;
        period      = 8'(cur_per);
        pulse_width = 6'(cur_pw);
        burst_count = 4'(cur_bc);
        @(posedge clk);
        model_step(en, st, sp);
        e.pulse  = (m_mode == 1 && m_pos < m_high) ? 1 : 0;
        e.strobe = (m_mode == 1 && m_pos == 0) ? 1 : 0;
        e.run    = (m_mode == 1) ? 1 : 0;
        e.done   = (m_mode == 2) ? 1 : 0;
        e.ph     = m_pos;
        e.emit   = m_emit;
        q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".pulse_out"}, 32'(pulse_out), 0);
        chk({tag, ".strobe"}, 32'(period_strobe), 0);
        chk({tag, ".running"}, 32'(running), 0);
        chk({tag, ".burst_done"}, 32'(burst_done), 0);
        chk({tag, ".phase"}, 32'(phase), 0);
        chk({tag, ".emitted"}, 32'(periods_emitted), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pulse_out", 32'(pulse_out), e.pulse);
                chk("period_strobe", 32'(period_strobe), e.strobe);
                chk("running", 32'(running), e.run);
                chk("burst_done", 32'(burst_done), e.done);
                chk("phase", 32'(phase), e.ph);
                chk("periods_emitted", 32'(periods_emitted), e.emit);
            end
        end
    end

    initial begin
        aresetn     = 1'b0;
        enable      = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        period      = '0;
        pulse_width = '0;
        burst_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        aresetn = 1'b1;

        cur_per = 10; cur_pw = 3; cur_bc = 0;
        step(1'b1, 1'b1, 1'b0);
        run(26);

        step(1'b1, 1'b1, 1'b0);
        run(4);
        cur_per = 6;
        run(20);

        step(1'b1, 1'b1, 1'b1);
        run(3);

        cur_per = 1; cur_pw = 5;
        step(1'b1, 1'b1, 1'b0);
        run(8);

        cur_per = 5; cur_pw = 0;
        step(1'b1, 1'b1, 1'b0);
        run(11);

        cur_per = 7; cur_pw = 6;
        step(1'b1, 1'b1, 1'b0);
        run(3);
        step(1'b1, 1'b1, 1'b0);
        run(4);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run(3);

        cur_per = 2; cur_pw = 1;
        step(1'b1, 1'b1, 1'b0);
        run(40);

        cur_per = 4; cur_pw = 2; cur_bc = 3;
        step(1'b1, 1'b1, 1'b0);
        run(16);
        step(1'b1, 1'b1, 1'b0);
        run(14);
        step(1'b1, 1'b0, 1'b1);
        run(2);

        cur_per = 9; cur_pw = 4; cur_bc = 0;
        step(1'b1, 1'b1, 1'b0);
        run(5);
        @(negedge clk);
        #1;
        enable  = 1'b1;
        start   = 1'b1;
        aresetn = 1'b0;
        #1;
        chk_zero("async_reset");
        m_mode = 0;
        m_pos  = 0;
        m_emit = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("held_reset");
        @(negedge clk);
        start   = 1'b0;
        aresetn = 1'b1;
        run(5);

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                cur_per = $urandom_range(0, 12);
                cur_pw  = $urandom_range(0, 15);
                cur_bc  = $urandom_range(0, 5);
            end
            step($urandom_range(0, 24) != 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 39) == 0);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
